hptdc_fifo_usb_reader: RTL and testbench

Drains TDC hit words from the HPTDC capture FIFO and streams them byte by byte into the USB bridge's 8-bit write FIFO.
- FIFO side: pops one word at a time with a one-cycle `read_enable` pulse and captures it on `output_ready`.
- USB side: serialises each word MSB-first onto an FT232H-style synchronous write interface (`usb_txe_n` / `usb_wr_n`).
- Sits between the FIFO read port and the USB transmit path.

---
 rtl/hptdc_fifo_usb_reader.sv | 130 +++++++++++++
 tb/tb_hptdc_fifo_usb_reader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/hptdc_fifo_usb_reader.sv
// Pops one HPTDC capture-FIFO word at a time and streams it MSB-first, byte by byte,
// into an FT232H-style synchronous USB write FIFO, retrying pops that get no data strobe.
module hptdc_fifo_usb_reader #(
  parameter int DATA_WIDTH = 24,
  parameter int WAIT_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_output_ready,
  output logic                  fifo_read_enable,
  input  logic                  usb_txe_n,
  output logic                  usb_wr_n,
  output logic [7:0]            usb_data,
  output logic                  busy,
  output logic [15:0]           words_sent,
  output logic [7:0]            retries
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CNT_W  = $clog2(WAIT_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_SEND} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rd_en_q, rd_en_d;
  logic                  wr_n_q, wr_n_d;
  logic                  busy_q, busy_d;
  logic [7:0]            data_q, data_d;
  logic [15:0]           words_q, words_d;
  logic [7:0]            retries_q, retries_d;
  logic                  byte_taken;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    wr_n_d     = wr_n_q;
    data_d     = data_q;
    words_d    = words_q;
    retries_d  = retries_q;
    byte_taken = !wr_n_q && !usb_txe_n;

    case (state_q)
      S_IDLE: begin
        wr_n_d = 1'b1;
        if (enable && !fifo_empty) state_d = S_REQ;
      end
      S_REQ: begin
        cnt_d   = CNT_W'(WAIT_LIMIT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (fifo_output_ready) begin
          shift_d = fifo_data;
          data_d  = fifo_data[DATA_WIDTH-1 -: 8];
          idx_d   = '0;
          wr_n_d  = usb_txe_n;
          state_d = S_SEND;
        end else if (cnt_q == '0) begin
          // Pop lost to a concurrent FIFO write: the word is still there, so ask again.
          if (retries_q != 8'hFF) retries_d = retries_q + 8'd1;
          state_d = fifo_empty ? S_IDLE : S_REQ;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_SEND: begin
        if (byte_taken && idx_q == IDX_W'(NBYTES - 1)) begin
          words_d = words_q + 16'd1;
          wr_n_d  = 1'b1;
          state_d = S_IDLE;
        end else if (byte_taken) begin
          shift_d = shift_q << 8;
          data_d  = shift_d[DATA_WIDTH-1 -: 8];
          idx_d   = idx_q + 1'b1;
          wr_n_d  = usb_txe_n;
        end else begin
          // Stalled byte stays on the bus; strobe follows the USB FIFO's space flag.
          wr_n_d = usb_txe_n;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rd_en_d = (state_d == S_REQ);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      rd_en_q   <= 1'b0;
      wr_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      data_q    <= 8'h00;
      words_q   <= 16'd0;
      retries_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      rd_en_q   <= rd_en_d;
      wr_n_q    <= wr_n_d;
      busy_q    <= busy_d;
      data_q    <= data_d;
      words_q   <= words_d;
      retries_q <= retries_d;
    end
  end

  assign fifo_read_enable = rd_en_q;
  assign usb_wr_n         = wr_n_q;
  assign usb_data         = data_q;
  assign busy             = busy_q;
  assign words_sent       = words_q;
  assign retries          = retries_q;

endmodule

// File: tb/tb_hptdc_fifo_usb_reader.sv
// Scoreboard bench: words loaded into the FIFO model push their expected bytes;
// a monitor pops and compares on every accepted USB write.
module tb_hptdc_fifo_usb_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        fifo_empty;
  logic [23:0] fifo_data = 24'h0;
  logic        fifo_output_ready = 1'b0;
  logic        fifo_read_enable;
  logic        usb_txe_n = 1'b1;
  logic        usb_wr_n;
  logic [7:0]  usb_data;
  logic        busy;
  logic [15:0] words_sent;
  logic [7:0]  retries;

  hptdc_fifo_usb_reader #(.DATA_WIDTH(24), .WAIT_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_output_ready(fifo_output_ready),
    .fifo_read_enable(fifo_read_enable), .usb_txe_n(usb_txe_n),
    .usb_wr_n(usb_wr_n), .usb_data(usb_data), .busy(busy),
    .words_sent(words_sent), .retries(retries)
  );

  always #5 clk = ~clk;

  logic [23:0] mem [256];
  logic [7:0]  wr_ptr = 8'd0;
  logic [7:0]  rd_ptr = 8'd0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  int   pops = 0, delivered = 0, drop_next = 0;
  int   bytes = 0, run = 0, max_run = 0;
  int   checks = 0, errors = 0;
  bit   pend = 1'b0;
  logic [7:0] exp_q [$];
  logic [7:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [23:0] w);
    mem[wr_ptr] = w;
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
    wr_ptr++;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_words(input int target, input int budget);
    int n = 0;
    while (words_sent != 16'(target) && n < budget) begin
      @(negedge clk); #1; n++;
    end
    check("words_sent_reached", 32'(words_sent), 32'(target));
  endtask

  task automatic wait_bytes(input int target, input int budget);
    int n = 0;
    while (bytes != target && n < budget) begin
      @(negedge clk); #1; n++;
    end
    check("bytes_reached", 32'(bytes), 32'(target));
  endtask

  task automatic wait_delivered(input int target, input int budget);
    int n = 0;
    while (delivered != target && n < budget) begin
      @(negedge clk); #1; n++;
    end
    check("pops_answered", 32'(delivered), 32'(target));
  endtask

  // FIFO model: answers a pop seen in cycle t with a data strobe in cycle t+1
  initial forever begin
    @(posedge clk); #1;
    fifo_output_ready = 1'b0;
    if (pend) begin
      pend = 1'b0;
      if (drop_next > 0) drop_next--;
      else if (!fifo_empty) begin
        fifo_data = mem[rd_ptr];
        rd_ptr++;
        fifo_output_ready = 1'b1;
        delivered++;
      end
    end
    @(negedge clk);
    if (rst_n && fifo_read_enable) begin
      pend = 1'b1;
      pops++;
    end
  end

  // USB monitor: a byte is accepted whenever wr_n and txe_n are both low
  initial forever begin
    @(negedge clk);
    if (rst_n && !usb_wr_n && !usb_txe_n) begin
      bytes++;
      run++;
      if (run > max_run) max_run = run;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got 0x%02h, expected none", usb_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("usb_byte", 32'(usb_data), 32'(mon_exp));
        $display("usb byte 0x%02h (expected 0x%02h)", usb_data, mon_exp);
      end
    end else begin
      run = 0;
    end
  end

  initial begin
    int b0, p0, w0, d0;
    usb_txe_n = 1'b0;
    enable    = 1'b1;
    rst_n     = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    #1;
    check("rst_read_enable", 32'(fifo_read_enable), 32'd0);
    check("rst_wr_n", 32'(usb_wr_n), 32'd1);
    check("rst_usb_data", 32'(usb_data), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_words_sent", 32'(words_sent), 32'd0);
    check("rst_retries", 32'(retries), 32'd0);
    cycles(20);
    check("no_pop_when_empty", 32'(pops), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // single word
    p0 = pops; b0 = bytes; max_run = 0;
    load(24'hABCDEF);
    wait_words(1, 100);
    cycles(3);
    check("single_pops", 32'(pops - p0), 32'd1);
    check("single_bytes", 32'(bytes - b0), 32'd3);
    check("single_consecutive", 32'(max_run), 32'd3);
    check("single_queue_drained", 32'(exp_q.size()), 32'd0);

    // USB backpressure after the first byte
    p0 = pops; b0 = bytes;
    load(24'hABCDEF);
    wait_bytes(b0 + 1, 100);
    @(posedge clk); #1;
    usb_txe_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_data", 32'(usb_data), 32'hCD);
      if (k > 0) check("stall_wr_n", 32'(usb_wr_n), 32'd1);
    end
    @(posedge clk); #1;
    usb_txe_n = 1'b0;
    wait_words(2, 100);
    cycles(3);
    check("stall_bytes", 32'(bytes - b0), 32'd3);
    check("stall_pops", 32'(pops - p0), 32'd1);

    // first pop lost to a FIFO write
    p0 = pops; b0 = bytes;
    drop_next = 1;
    load(24'h123456);
    wait_words(3, 100);
    cycles(3);
    check("retry_count", 32'(retries), 32'd1);
    check("retry_pops", 32'(pops - p0), 32'd2);
    check("retry_bytes", 32'(bytes - b0), 32'd3);

    // drain 100 words, pausing enable after word 50 is popped
    enable = 1'b0;
    cycles(2);
    p0 = pops; d0 = delivered; w0 = 32'(words_sent);
    for (int i = 0; i < 100; i++) load(24'h100000 + 24'(i) * 24'h010101);
    enable = 1'b1;
    wait_delivered(d0 + 50, 1000);
    enable = 1'b0;
    wait_words(w0 + 50, 100);
    cycles(20);
    check("pause_words", 32'(words_sent), 32'(w0 + 50));
    check("pause_pops", 32'(pops - p0), 32'd50);
    check("pause_busy", 32'(busy), 32'd0);
    enable = 1'b1;
    wait_words(w0 + 100, 2000);
    cycles(3);
    check("drain_pops", 32'(pops - p0), 32'd100);
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);

    // asynchronous reset after the first byte of a word
    b0 = bytes;
    load(24'h5A6B7C);
    wait_bytes(b0 + 1, 100);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_wr_n", 32'(usb_wr_n), 32'd1);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_read_enable", 32'(fifo_read_enable), 32'd0);
    exp_q.delete();
    cycles(2);
    rst_n = 1'b1;
    #1;
    check("after_rst_words", 32'(words_sent), 32'd0);
    check("after_rst_retries", 32'(retries), 32'd0);
    b0 = bytes;
    load(24'h9E8D7C);
    wait_words(1, 100);
    cycles(3);
    check("after_rst_bytes", 32'(bytes - b0), 32'd3);
    check("after_rst_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
